victim_miss_ctrl: RTL and testbench

VICTIM_MISS_CTRL -- requirements
Module: victim_miss_ctrl

---
 rtl/victim_miss_ctrl.sv | 155 +++++++++++++++
 tb/tb_victim_miss_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/victim_miss_ctrl.sv
// victim_miss_ctrl: MEM-stage cache miss controller with a victim cache.
// An L1 hit passes straight through. A victim hit swaps lines for SWAP_CYCLES
// cycles. A full miss optionally writes back a dirty line, then fetches and
// fills. stall holds the pipeline from the first cycle of any non-L1-hit access
// until the DONE cycle, where the held access retires.
module victim_miss_ctrl #(
  parameter int unsigned SWAP_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_req,
  input  logic             hit_l1,
  input  logic             hit_victim,
  input  logic             dirty_evict,
  input  logic             mem_ready,
  output logic             stall,
  output logic             swap_en,
  output logic             wb_req,
  output logic             fetch_req,
  output logic             fill_en,
  output logic [CNT_W-1:0] l1_hits,
  output logic [CNT_W-1:0] victim_hits,
  output logic [CNT_W-1:0] misses
);

  localparam int unsigned SC_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SWAP  = 3'd1,
    S_WB    = 3'd2,
    S_FETCH = 3'd3,
    S_FILL  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           r_state;
  logic [SC_W-1:0]  r_swap_left;
  logic             r_swap_en;
  logic             r_wb_req;
  logic             r_fetch_req;
  logic             r_fill_en;
  logic [CNT_W-1:0] r_l1_hits;
  logic [CNT_W-1:0] r_victim_hits;
  logic [CNT_W-1:0] r_misses;

  logic w_idle;
  logic w_req;
  logic w_l1_hit;
  logic w_vic_hit;
  logic w_miss;
  logic w_busy;

  // Classify the access presented in IDLE; other states ignore the request
  assign w_idle    = (r_state == S_IDLE);
  assign w_req     = w_idle & mem_req;
  assign w_l1_hit  = w_req & hit_l1;
  assign w_vic_hit = w_req & ~hit_l1 & hit_victim;
  assign w_miss    = w_req & ~hit_l1 & ~hit_victim;
  assign w_busy    = (r_state != S_IDLE) && (r_state != S_DONE);

  // Stall is combinational so a missing access is held from its first cycle;
  // gated by reset so it reads 0 while reset is asserted
  assign stall = reset & (w_busy | (w_req & ~hit_l1));

  assign swap_en     = r_swap_en;
  assign wb_req      = r_wb_req;
  assign fetch_req   = r_fetch_req;
  assign fill_en     = r_fill_en;
  assign l1_hits     = r_l1_hits;
  assign victim_hits = r_victim_hits;
  assign misses      = r_misses;

  // State register with strobes registered to match the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_swap_left <= '0;
      r_swap_en   <= 1'b0;
      r_wb_req    <= 1'b0;
      r_fetch_req <= 1'b0;
      r_fill_en   <= 1'b0;
    end else begin
      r_swap_en   <= 1'b0;
      r_wb_req    <= 1'b0;
      r_fetch_req <= 1'b0;
      r_fill_en   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_vic_hit) begin
            r_state     <= S_SWAP;
            r_swap_left <= SC_W'(SWAP_CYCLES - 1);
            r_swap_en   <= 1'b1;
          end else if (w_miss) begin
            if (dirty_evict) begin
              r_state  <= S_WB;
              r_wb_req <= 1'b1;
            end else begin
              r_state     <= S_FETCH;
              r_fetch_req <= 1'b1;
            end
          end
        end
        S_SWAP: begin
          if (r_swap_left == '0) begin
            r_state <= S_DONE;
          end else begin
            r_swap_left <= r_swap_left - SC_W'(1);
            r_swap_en   <= 1'b1;
          end
        end
        S_WB: begin
          if (mem_ready) begin
            r_state     <= S_FETCH;
            r_fetch_req <= 1'b1;
          end else begin
            r_wb_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (mem_ready) begin
            r_state   <= S_FILL;
            r_fill_en <= 1'b1;
          end else begin
            r_fetch_req <= 1'b1;
          end
        end
        S_FILL:  r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating statistics counters, updated only for accesses accepted in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_l1_hits     <= '0;
      r_victim_hits <= '0;
      r_misses      <= '0;
    end else begin
      if (w_l1_hit && (r_l1_hits != '1)) begin
        r_l1_hits <= r_l1_hits + CNT_W'(1);
      end
      if (w_vic_hit && (r_victim_hits != '1)) begin
        r_victim_hits <= r_victim_hits + CNT_W'(1);
      end
      if (w_miss && (r_misses != '1)) begin
        r_misses <= r_misses + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_victim_miss_ctrl.sv
// Directed bench for victim_miss_ctrl (SWAP_CYCLES=2, CNT_W=4).
module tb_victim_miss_ctrl;

  localparam int unsigned SWAP_CYCLES = 2;
  localparam int unsigned CNT_W       = 4;

  logic             clk;
  logic             reset;
  logic             mem_req;
  logic             hit_l1;
  logic             hit_victim;
  logic             dirty_evict;
  logic             mem_ready;
  logic             stall;
  logic             swap_en;
  logic             wb_req;
  logic             fetch_req;
  logic             fill_en;
  logic [CNT_W-1:0] l1_hits;
  logic [CNT_W-1:0] victim_hits;
  logic [CNT_W-1:0] misses;

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned n_stall, n_swap, n_wb, n_fetch, n_fill, n_excl;

  victim_miss_ctrl #(
    .SWAP_CYCLES(SWAP_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .hit_l1     (hit_l1),
    .hit_victim (hit_victim),
    .dirty_evict(dirty_evict),
    .mem_ready  (mem_ready),
    .stall      (stall),
    .swap_en    (swap_en),
    .wb_req     (wb_req),
    .fetch_req  (fetch_req),
    .fill_en    (fill_en),
    .l1_hits    (l1_hits),
    .victim_hits(victim_hits),
    .misses     (misses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and let outputs settle
  task automatic step(input logic req, input logic h1, input logic hv,
                      input logic de, input logic mr);
    @(negedge clk);
    mem_req     = req;
    hit_l1      = h1;
    hit_victim  = hv;
    dirty_evict = de;
    mem_ready   = mr;
    #1;
  endtask

  // Accumulate strobe activity for the current cycle
  task automatic tally();
    n_stall += 32'(stall);
    n_swap  += 32'(swap_en);
    n_wb    += 32'(wb_req);
    n_fetch += 32'(fetch_req);
    n_fill  += 32'(fill_en);
    if ((32'(swap_en) + 32'(wb_req) + 32'(fetch_req) + 32'(fill_en)) > 1) n_excl++;
  endtask

  task automatic clear_tally();
    n_stall = 0; n_swap = 0; n_wb = 0; n_fetch = 0; n_fill = 0; n_excl = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_tally();
    reset       = 1'b0;
    mem_req     = 1'b1;
    hit_l1      = 1'b0;
    hit_victim  = 1'b0;
    dirty_evict = 1'b0;
    mem_ready   = 1'b0;
    #12;
    check("rst_stall",  32'(stall), 0);
    check("rst_strobe", 32'({swap_en, wb_req, fetch_req, fill_en}), 0);
    check("rst_cnt",    32'({l1_hits, victim_hits, misses}), 0);
    @(negedge clk);
    mem_req = 1'b0;
    reset   = 1'b1;

    // Three L1 hits: never stall
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("hit_stall", 32'(stall), 0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("hit_l1_cnt", 32'(l1_hits), 3);
    check("hit_miss_cnt", 32'(misses), 0);

    // Victim hit; requests driven during SWAP/DONE must be ignored
    clear_tally();
    for (int c = 0; c < 6; c++) begin
      if (c == 0)      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      else if (c <= 3) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      else             step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tally();
      if (c == 3) check("vic_done_stall", 32'(stall), 0);
    end
    check("vic_stall_cyc", n_stall, 3);
    check("vic_swap_cyc",  n_swap, 2);
    check("vic_wb_cyc",    n_wb, 0);
    check("vic_cnt",       32'(victim_hits), 1);
    check("vic_l1_ignored", 32'(l1_hits), 3);
    check("vic_excl",      n_excl, 0);

    // Dirty miss: mem_ready on 3rd WB cycle and 2nd FETCH cycle
    clear_tally();
    for (int c = 0; c < 10; c++) begin
      step((c == 0), 1'b0, 1'b0, (c == 0), ((c == 3) || (c == 5)));
      tally();
    end
    check("dirty_wb_cyc",    n_wb, 3);
    check("dirty_fetch_cyc", n_fetch, 2);
    check("dirty_fill_cyc",  n_fill, 1);
    check("dirty_stall_cyc", n_stall, 7);
    check("dirty_miss_cnt",  32'(misses), 1);
    check("dirty_excl",      n_excl, 0);

    // Clean miss with mem_ready held high: shortest miss
    clear_tally();
    for (int c = 0; c < 8; c++) begin
      step((c == 0), 1'b0, 1'b0, 1'b0, 1'b1);
      tally();
    end
    check("clean_stall_cyc", n_stall, 3);
    check("clean_wb_cyc",    n_wb, 0);
    check("clean_fetch_cyc", n_fetch, 1);
    check("clean_fill_cyc",  n_fill, 1);
    check("clean_miss_cnt",  32'(misses), 2);

    // mem_req low in IDLE: no stall, no counting
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("noreq_stall", 32'(stall), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("noreq_cnt", 32'({l1_hits, victim_hits, misses}), 32'({4'd3, 4'd1, 4'd2}));

    // Reset asserted while in FETCH takes effect before the next edge
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fetch_pre_rst", 32'(fetch_req), 1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_fetch_req", 32'(fetch_req), 0);
    check("rst_mid_stall", 32'(stall), 0);
    check("rst_mid_cnt",   32'({l1_hits, victim_hits, misses}), 0);
    @(negedge clk);
    mem_req = 1'b0;
    reset   = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_idle", 32'({stall, swap_en, wb_req, fetch_req, fill_en}), 0);

    // Saturation: 17 hits into a 4-bit counter
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sat_l1_cnt",   32'(l1_hits), 15);
    check("sat_miss_cnt", 32'(misses), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
